// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that feeds one UART transmitter
// and holds off new grants until the frame in flight has finished.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int FRAME_CYCLES = 10
) (
  input  logic                         real_clk,
  input  logic                         real_rst,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         uart_run,
  output logic [DATA_W-1:0]            uart_msg,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         tx_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FRAME_CYCLES + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d, gid_q, gid_d, pick, cand;
  logic [DATA_W-1:0] msg_q, msg_d, pick_data;
  logic              found, grant;

  // Scan from farthest to nearest so the nearest valid index after ptr_q wins.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (pick == IW'(k)) pick_data = req_data[k*DATA_W +: DATA_W];
  end

  // Reset also masks the combinational ready so it reads 0 while real_rst is held.
  assign grant     = (state_q == S_IDLE) && enable && found && !real_rst;
  assign req_ready = grant ? (NUM_REQ'(1) << pick) : '0;
  assign uart_run  = state_q == S_LAUNCH;
  assign busy      = state_q != S_IDLE;
  assign tx_done   = (state_q == S_BUSY) && (cnt_q == '0);
  assign uart_msg  = msg_q;
  assign grant_id  = gid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    msg_d   = msg_q;
    case (state_q)
      S_IDLE: if (grant) begin
        state_d = S_LAUNCH;
        msg_d   = pick_data;
        gid_d   = pick;
        ptr_d   = pick;
      end
      S_LAUNCH: begin
        state_d = S_BUSY;
        cnt_d   = CW'(FRAME_CYCLES - 1);
      end
      S_BUSY: begin
        state_d = (cnt_q == '0) ? S_IDLE : S_BUSY;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge real_clk or posedge real_rst) begin
    if (real_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      msg_q   <= msg_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and random checks against a frame-timeline model.
module tb_uart_tx_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int F = 10;

  logic                 real_clk = 1'b0;
  logic                 real_rst;
  logic                 enable;
  logic [N-1:0]         req_valid;
  logic [N*W-1:0]       req_data;
  logic [N-1:0]         req_ready;
  logic                 uart_run;
  logic [W-1:0]         uart_msg;
  logic                 busy;
  logic [$clog2(N)-1:0] grant_id;
  logic                 tx_done;

  uart_tx_scheduler #(.NUM_REQ(N), .DATA_W(W), .FRAME_CYCLES(F)) dut (
    .real_clk(real_clk), .real_rst(real_rst), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .uart_run(uart_run), .uart_msg(uart_msg), .busy(busy),
    .grant_id(grant_id), .tx_done(tx_done)
  );

  always #5 real_clk = ~real_clk;

  int checks = 0;
  int passed = 0;
  // age = cycles since the last grant; 1 is the run cycle, F+1 the last busy cycle, beyond is idle
  int age = F + 2;
  int m_ptr = N - 1;
  int m_gid = 0;
  logic [W-1:0] m_msg = '0;
  int cyc = 0;
  int run_cyc[$];
  logic [W-1:0] run_byte[$];
  int done_cyc[$];
  logic [N-1:0] rdy_val[$];
  int n0, n1, n2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    age = F + 2;
    m_ptr = N - 1;
    m_gid = 0;
    m_msg = '0;
  endtask

  task automatic tick();
    logic [N-1:0] er;
    logic ebusy;
    int g;
    @(negedge real_clk);
    ebusy = (age >= 1) && (age <= F + 1);
    er = '0;
    g = -1;
    if (!ebusy && enable)
      for (int k = N; k >= 1; k--) if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", req_ready, er);
    chk("run", uart_run, age == 1);
    chk("busy", busy, ebusy);
    chk("done", tx_done, age == F + 1);
    chk("msg", uart_msg, m_msg);
    chk("gid", grant_id, m_gid);
    if (uart_run) begin
      run_cyc.push_back(cyc);
      run_byte.push_back(uart_msg);
    end
    if (tx_done) done_cyc.push_back(cyc);
    if (req_ready != '0) rdy_val.push_back(req_ready);
    @(posedge real_clk);
    if (g >= 0) begin
      m_ptr = g;
      m_gid = g;
      m_msg = req_data[g*W +: W];
      age = 1;
    end else if (age <= F + 1) age++;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    real_rst = 1'b1;
    enable = 1'b1;
    req_valid = '0;
    model_reset();
    #1;
    chk("rst_ready", req_ready, '0);
    chk("rst_run", uart_run, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_msg", uart_msg, '0);
    chk("rst_gid", grant_id, '0);
    @(posedge real_clk);
    #1;
    real_rst = 1'b0;
  endtask

  initial begin
    real_rst = 1'b1;
    enable = 1'b1;
    req_valid = '0;
    req_data = '0;
    // Test 1: single requester after reset
    do_reset();
    req_data[2*W +: W] = 8'hA5;
    req_valid = 4'b0100;
    n0 = cyc; n1 = run_cyc.size(); n2 = done_cyc.size();
    repeat (12) tick();
    req_valid = '0;
    tick();
    chk("t1_run_cycle", run_cyc[n1] - n0, 1);
    chk("t1_run_byte", run_byte[n1], 8'hA5);
    chk("t1_done_cycle", done_cyc[n2] - n0, 11);
    // Test 2: full rotation with all requesters valid
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    n1 = run_cyc.size();
    repeat (60) tick();
    req_valid = '0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) chk("t2_byte", run_byte[n1 + i], 8'h10 + 8'(i % 4));
    for (int i = 1; i < 5; i++) chk("t2_spacing", run_cyc[n1 + i] - run_cyc[n1 + i - 1], F + 2);
    // Test 3: lone requester granted back to back
    do_reset();
    req_data[1*W +: W] = 8'h3C;
    req_valid = 4'b0010;
    n0 = rdy_val.size();
    repeat (36) tick();
    req_valid = '0;
    repeat (2) tick();
    chk("t3_grants", rdy_val.size() - n0, 3);
    for (int i = 0; i < 3; i++) chk("t3_onehot", rdy_val[n0 + i], 4'b0010);
    // Test 4: enable dropped mid-frame, restored with request pending
    do_reset();
    req_data[0 +: W] = 8'h77;
    req_valid = 4'b0001;
    repeat (3) tick();
    enable = 1'b0;
    n0 = rdy_val.size(); n2 = done_cyc.size();
    repeat (15) tick();
    chk("t4_done", done_cyc.size() - n2, 1);
    chk("t4_no_ready", rdy_val.size() - n0, 0);
    enable = 1'b1;
    tick();
    chk("t4_regrant", rdy_val.size() - n0, 1);
    req_valid = '0;
    repeat (13) tick();
    // Test 5: reset in the 4th busy cycle
    do_reset();
    req_data = {8'hD3, 8'h00, 8'h00, 8'h5A};
    req_valid = 4'b0001;
    n2 = done_cyc.size();
    repeat (5) tick();
    real_rst = 1'b1;
    req_valid = 4'b1001;
    model_reset();
    #1;
    chk("t5_run", uart_run, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", tx_done, 1'b0);
    chk("t5_ready", req_ready, '0);
    chk("t5_msg", uart_msg, '0);
    @(posedge real_clk);
    #1;
    real_rst = 1'b0;
    tick();
    chk("t5_first", rdy_val[rdy_val.size() - 1], 4'b0001);
    chk("t5_no_done", done_cyc.size() - n2, 0);
    req_valid = 4'b1000;
    repeat (13) tick();
    req_valid = '0;
    repeat (12) tick();
    // Test 6: requester pulses valid only while busy
    do_reset();
    req_data[0 +: W] = 8'h21;
    req_data[3*W +: W] = 8'hE8;
    req_valid = 4'b0001;
    n0 = rdy_val.size();
    tick();
    req_valid = '0;
    repeat (3) tick();
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (12) tick();
    chk("t6_grants", rdy_val.size() - n0, 1);
    chk("t6_only_req0", rdy_val[n0], 4'b0001);
    // Random traffic against the model
    do_reset();
    repeat (400) begin
      for (int k = 0; k < N; k++) if (!req_valid[k]) req_data[k*W +: W] = 8'($urandom);
      req_valid = 4'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
